// File: rtl/ls395_seq_pkg.sv
// Shared types for the LS395A shift sequencer.
// State encoding, register width and requester id.
package ls395_seq_pkg;

    localparam int SR_WIDTH = 4;
    localparam int CNT_W    = 2;

    typedef logic [CNT_W-1:0]    cnt_t;
    typedef logic [SR_WIDTH-1:0] word_t;
    typedef logic                req_id_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with one-hot grant.
// The pointer names the requester holding priority.
module rr_arbiter2
    import ls395_seq_pkg::*;
(
    input  logic       clk_i,
    input  logic       clr_i,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o,
    output req_id_t    id_o
);

    req_id_t ptr_q;
    req_id_t ptr_d;

    always_comb begin
        gnt_o = 2'b00;
        id_o  = 1'b0;
        if (en_i) begin
            if (ptr_q == 1'b0) begin
                if (req_i[0]) begin
                    gnt_o = 2'b01;
                    id_o  = 1'b0;
                end else if (req_i[1]) begin
                    gnt_o = 2'b10;
                    id_o  = 1'b1;
                end
            end else begin
                if (req_i[1]) begin
                    gnt_o = 2'b10;
                    id_o  = 1'b1;
                end else if (req_i[0]) begin
                    gnt_o = 2'b01;
                    id_o  = 1'b0;
                end
            end
        end
    end

    assign ptr_d = (gnt_o != 2'b00) ? ~id_o : ptr_q;

    always_ff @(posedge clk_i) begin
        if (clr_i) ptr_q <= 1'b0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/ls395_shift_sequencer.sv
// Shares one LS395A-style register between two requesters:
// load, shift out MSB-first, loopback-check, return rx nibble.
module ls395_shift_sequencer
    import ls395_seq_pkg::*;
#(
    parameter int GAP_CYCLES = 0
) (
    input  logic                iClk,
    input  logic                iClr,
    input  logic [1:0]          iReq,
    input  logic [SR_WIDTH-1:0] iData0,
    input  logic [SR_WIDTH-1:0] iData1,
    input  logic                iSerIn,
    output logic [1:0]          oGnt,
    output logic                oSrClr,
    output logic                oSrLdSh,
    output logic                oSrOC,
    output logic                oSrSer,
    output logic [SR_WIDTH-1:0] oSrData,
    input  logic [SR_WIDTH-1:0] iSrQ,
    input  logic                iSrCarry,
    output logic                oBusy,
    output logic                oDone,
    output logic                oDoneId,
    output logic [SR_WIDTH-1:0] oRxData,
    output logic                oVerifyErr
);

    state_e  state_q, state_d;
    cnt_t    cnt_q, cnt_d;
    word_t   data_q, data_d;
    req_id_t id_q, id_d;
    word_t   chk_q, chk_d;
    word_t   rx_q, rx_d;
    logic    err_q, err_d;
    logic [3:0] gap_q, gap_d;

    logic    arb_en;
    req_id_t arb_id;

    assign arb_en = (state_q == ST_IDLE) && (gap_q == 4'd0) && !iClr;

    rr_arbiter2 u_arb (
        .clk_i (iClk),
        .clr_i (iClr),
        .req_i (iReq),
        .en_i  (arb_en),
        .gnt_o (oGnt),
        .id_o  (arb_id)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        id_d    = id_q;
        chk_d   = chk_q;
        rx_d    = rx_q;
        err_d   = err_q;
        gap_d   = gap_q;
        unique case (state_q)
            ST_IDLE: begin
                if (gap_q != 4'd0) begin
                    gap_d = gap_q - 4'd1;
                end else if (oGnt != 2'b00) begin
                    data_d  = oGnt[1] ? iData1 : iData0;
                    id_d    = arb_id;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                chk_d   = {chk_q[SR_WIDTH-2:0], iSrCarry};
                cnt_d   = '0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                // Carry bits arrive c3 first, so they assemble MSB-first.
                if (cnt_q != cnt_t'(SR_WIDTH - 1)) begin
                    chk_d = {chk_q[SR_WIDTH-2:0], iSrCarry};
                    cnt_d = cnt_q + cnt_t'(1);
                end else begin
                    rx_d    = iSrQ;
                    err_d   = (chk_q != data_q);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                gap_d   = 4'(GAP_CYCLES);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iClr) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            id_q    <= 1'b0;
            chk_q   <= '0;
            rx_q    <= '0;
            err_q   <= 1'b0;
            gap_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            id_q    <= id_d;
            chk_q   <= chk_d;
            rx_q    <= rx_d;
            err_q   <= err_d;
            gap_q   <= gap_d;
        end
    end

    assign oSrClr     = (state_q == ST_IDLE);
    assign oSrOC      = (state_q == ST_IDLE);
    assign oSrLdSh    = (state_q == ST_LOAD);
    assign oSrSer     = (state_q == ST_SHIFT) && iSerIn;
    assign oSrData    = data_q;
    assign oBusy      = (state_q != ST_IDLE);
    assign oDone      = (state_q == ST_DONE);
    assign oDoneId    = id_q;
    assign oRxData    = rx_q;
    assign oVerifyErr = err_q;

endmodule
